// File: rtl/led_pattern_sequencer_if.sv
// Config channel of the LED sequencer. A transfer happens on the hwclk edge where
// cfg_valid && cfg_ready; the source holds cfg_valid, cfg_mode and cfg_steps stable until then.
interface led_pattern_sequencer_if #(
  parameter int STEP_W = 8
) ();
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_mode;
  logic [STEP_W-1:0] cfg_steps;

  modport master (output cfg_valid, output cfg_mode, output cfg_steps, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_mode, input cfg_steps, output cfg_ready);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Steps an 8-LED pattern once every DIV hwclk cycles for a configured number of steps
// (or until stopped), then blanks the LEDs and pulses done.
module led_pattern_sequencer #(
  parameter int DIV    = 262144,
  parameter int STEP_W = 8
) (
  input  logic                   hwclk,
  input  logic                   rst,
  led_pattern_sequencer_if.slave cfg,
  input  logic                   stop,
  output logic                   busy,
  output logic                   done,
  output logic                   led1,
  output logic                   led2,
  output logic                   led3,
  output logic                   led4,
  output logic                   led5,
  output logic                   led6,
  output logic                   led7,
  output logic                   led8,
  output logic                   dbg_state_o
);
  localparam int PW = $clog2(DIV);

  typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_e;
  typedef enum logic [1:0] {
    MODE_BINARY = 2'd0, MODE_SCAN = 2'd1, MODE_BLINK = 2'd2, MODE_FILL = 2'd3
  } mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [7:0]        pattern_q, pattern_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              dir_up_q, dir_up_d;
  logic              done_q, done_d;

  logic              tick;
  logic [STEP_W-1:0] step_inc;
  logic [7:0]        adv_pattern;
  logic              adv_dir_up;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_BINARY;
      pattern_q <= 8'h00;
      presc_q   <= '0;
      step_q    <= '0;
      steps_q   <= '0;
      dir_up_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      presc_q   <= presc_d;
      step_q    <= step_d;
      steps_q   <= steps_d;
      dir_up_q  <= dir_up_d;
      done_q    <= done_d;
    end
  end

  assign tick     = (presc_q == PW'(DIV - 1));
  assign step_inc = step_q + STEP_W'(1);

  // Pattern the display would move to on a non-terminating tick.
  always_comb begin
    adv_pattern = pattern_q;
    adv_dir_up  = dir_up_q;
    case (mode_q)
      MODE_BINARY: adv_pattern = pattern_q + 8'd1;
      MODE_SCAN: begin
        if (dir_up_q) begin
          if (pattern_q == 8'h80) begin
            adv_pattern = 8'h40;
            adv_dir_up  = 1'b0;
          end else begin
            adv_pattern = {pattern_q[6:0], 1'b0};
          end
        end else begin
          if (pattern_q == 8'h01) begin
            adv_pattern = 8'h02;
            adv_dir_up  = 1'b1;
          end else begin
            adv_pattern = {1'b0, pattern_q[7:1]};
          end
        end
      end
      MODE_BLINK: adv_pattern = ~pattern_q;
      MODE_FILL:  adv_pattern = (pattern_q == 8'hFF) ? 8'h00 : {pattern_q[6:0], 1'b1};
      default:    adv_pattern = pattern_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    presc_d   = presc_q;
    step_d    = step_q;
    steps_d   = steps_q;
    dir_up_d  = dir_up_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        pattern_d = 8'h00;
        if (cfg.cfg_valid) begin
          state_d  = RUN;
          mode_d   = mode_e'(cfg.cfg_mode);
          steps_d  = cfg.cfg_steps;
          presc_d  = '0;
          step_d   = '0;
          dir_up_d = 1'b1;
          case (mode_e'(cfg.cfg_mode))
            MODE_SCAN:  pattern_d = 8'h01;
            MODE_BLINK: pattern_d = 8'hFF;
            default:    pattern_d = 8'h00;
          endcase
        end
      end
      RUN: begin
        // stop takes priority over a coincident tick: no advance, no done.
        if (stop) begin
          state_d   = IDLE;
          pattern_d = 8'h00;
          presc_d   = '0;
        end else if (tick) begin
          presc_d = '0;
          step_d  = step_inc;
          if ((steps_q != '0) && (step_inc == steps_q)) begin
            state_d   = IDLE;
            pattern_d = 8'h00;
            done_d    = 1'b1;
          end else begin
            pattern_d = adv_pattern;
            dir_up_d  = adv_dir_up;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg.cfg_ready = (state_q == IDLE);
  assign busy          = (state_q == RUN);
  assign done          = done_q;
  assign dbg_state_o   = state_q;
  assign {led8, led7, led6, led5, led4, led3, led2, led1} = pattern_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with DIV=4: table of pattern runs plus
// hand-written stop, back-to-back config and mid-run reset sequences.
module tb_led_pattern_sequencer;
  localparam int DIV = 4;

  logic hwclk = 1'b0;
  logic rst, stop, busy, done, dbg_state;
  logic led1, led2, led3, led4, led5, led6, led7, led8;
  logic [7:0] leds;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  led_pattern_sequencer_if #(.STEP_W(8)) cfg_bus ();

  led_pattern_sequencer #(.DIV(DIV), .STEP_W(8)) dut (
    .hwclk(hwclk), .rst(rst), .cfg(cfg_bus), .stop(stop), .busy(busy), .done(done),
    .led1(led1), .led2(led2), .led3(led3), .led4(led4),
    .led5(led5), .led6(led6), .led7(led7), .led8(led8),
    .dbg_state_o(dbg_state)
  );

  assign leds = {led8, led7, led6, led5, led4, led3, led2, led1};

  // Clock / watchdog
  always #5 hwclk = ~hwclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [1:0]        mode;
    logic [7:0]        steps;
    logic [4:0]        n;
    logic [0:15][7:0]  pats;
  } vec_t;

  vec_t vec [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge right after acceptance.
  task automatic send_cfg(input logic [1:0] m, input logic [7:0] s);
    logic ok;
    ok = 1'b0;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_mode  = m;
    cfg_bus.cfg_steps = s;
    for (int i = 0; i < 50; i++) begin
      if (cfg_bus.cfg_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge hwclk);
    end
    chk("cfg_accept", {31'd0, ok}, 32'd1);
    @(negedge hwclk);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic run_patterns(input int n);
    logic [7:0] p;
    for (int k = 0; k < n; k++) begin
      p = exp_q.pop_front();
      for (int c = 0; c < DIV; c++) begin
        chk("run_leds", {24'd0, leds}, {24'd0, p});
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_done", {31'd0, done}, 32'd0);
        chk("run_ready", {31'd0, cfg_bus.cfg_ready}, 32'd0);
        @(negedge hwclk);
      end
    end
  endtask

  task automatic check_done();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_leds", {24'd0, leds}, 32'd0);
    chk("done_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    @(negedge hwclk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_leds"}, {24'd0, leds}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_ready"}, {31'd0, cfg_bus.cfg_ready}, 32'd1);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    vec[0] = '{mode: 2'd0, steps: 8'd3, n: 5'd3,
               pats: {8'h00, 8'h01, 8'h02, {13{8'h00}}}};
    vec[1] = '{mode: 2'd1, steps: 8'd0, n: 5'd16,
               pats: {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                      8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02}};
    vec[2] = '{mode: 2'd3, steps: 8'd10, n: 5'd10,
               pats: {8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                      8'hFF, 8'h00, {6{8'h00}}}};
    vec[3] = '{mode: 2'd2, steps: 8'd4, n: 5'd4,
               pats: {8'hFF, 8'h00, 8'hFF, 8'h00, {12{8'h00}}}};

    rst = 1'b1;
    stop = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_mode  = 2'd0;
    cfg_bus.cfg_steps = 8'd0;
    @(negedge hwclk);
    @(negedge hwclk);
    check_idle("reset");
    rst = 1'b0;
    stop = 1'b1;
    @(negedge hwclk);
    stop = 1'b0;
    check_idle("idle_stop_ignored");

    // Table-driven pattern runs
    for (int i = 0; i < 4; i++) begin
      send_cfg(vec[i].mode, vec[i].steps);
      for (int k = 0; k < int'(vec[i].n); k++) exp_q.push_back(vec[i].pats[k]);
      run_patterns(int'(vec[i].n));
      if (vec[i].steps != 8'd0) begin
        check_done();
      end else begin
        stop = 1'b1;
        @(negedge hwclk);
        stop = 1'b0;
        check_idle("vec_stop");
      end
    end

    // stop mid-pattern in an endless BLINK run
    send_cfg(2'd2, 8'd0);
    for (int c = 1; c <= 5; c++) begin
      chk("blink_leds", {24'd0, leds}, (c <= DIV) ? 32'hFF : 32'h00);
      @(negedge hwclk);
    end
    stop = 1'b1;
    @(negedge hwclk);
    stop = 1'b0;
    check_idle("stop_mid");
    for (int c = 0; c < 6; c++) begin
      chk("stop_no_done", {31'd0, done}, 32'd0);
      @(negedge hwclk);
    end

    // stop on the same edge as the terminating tick: no done
    send_cfg(2'd0, 8'd1);
    for (int c = 1; c < DIV; c++) @(negedge hwclk);
    stop = 1'b1;
    @(negedge hwclk);
    stop = 1'b0;
    check_idle("stop_tick");
    @(negedge hwclk);
    chk("stop_tick_no_done", {31'd0, done}, 32'd0);

    // config held during a run is taken the cycle after done
    send_cfg(2'd0, 8'd2);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_mode  = 2'd3;
    cfg_bus.cfg_steps = 8'd3;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    run_patterns(2);
    check_done();
    cfg_bus.cfg_valid = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    run_patterns(3);
    check_done();

    // reset in the middle of a SCAN run
    send_cfg(2'd1, 8'd0);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    run_patterns(3);
    chk("scan_before_rst", {24'd0, leds}, 32'h08);
    rst = 1'b1;
    @(negedge hwclk);
    rst = 1'b0;
    check_idle("mid_rst");
    send_cfg(2'd1, 8'd2);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    run_patterns(2);
    check_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Controller that sequences the 8-LED bank from a prescaled step tick in place of a raw free-running counter. Accepts a pattern mode and step count over a valid/ready config handshake. Runs the pattern for N steps, or forever, then blanks the LEDs and pulses done. Sits between board-level control logic (buttons or host) and the LED pins; clocked from hwclk.

Parameters:
DIV, 262144, hwclk cycles per pattern step (legal range >= 2); prescaler width = clog2(DIV)
STEP_W, 8, width of step-count config and internal step counter

Ports:
hwclk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
cfg_valid  input  1  config request; source holds it until accepted
cfg_ready  output  1  high when the block can accept config (state IDLE)
cfg_mode  input  2  0=BINARY, 1=SCAN, 2=BLINK, 3=FILL
cfg_steps  input  STEP_W  number of patterns to display; 0 = run until stop
stop  input  1  abort request; level-sampled each cycle
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on normal completion
led1..led8  output  1 each  LED drivers; led1 = pattern bit0 ... led8 = pattern bit7

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; pattern=0x00; prescaler=0; step counter=0; done=0. All LED outputs 0, busy=0. rst overrides every other input.
- cfg_ready = (state==IDLE); combinational from state. busy = (state==RUN). LED outputs come directly from the registered pattern.
- IDLE: LEDs 0. If cfg_valid&&cfg_ready at an edge:
  - latch mode and steps;
  - prescaler=0, step counter=0;
  - load initial pattern: BINARY 0x00, SCAN 0x01 with direction=up, BLINK 0xFF, FILL 0x00;
  - state=RUN from the next cycle. The first pattern is visible the cycle after acceptance.
- stop in IDLE is ignored.
- RUN: prescaler increments each cycle; tick = (prescaler==DIV-1). On tick, prescaler returns to 0, so each pattern is held exactly DIV cycles.
- On tick, the step counter increments. Termination applies when latched steps!=0 and the incremented count == steps:
  - state=IDLE, pattern=0x00, done=1 for exactly one cycle;
  - pattern is not advanced;
  - result: exactly N distinct patterns shown, each for DIV cycles; busy high for N*DIV cycles.
- On a non-terminating tick, the pattern advances:
  - BINARY: pattern+1 mod 256 (0xFF->0x00).
  - SCAN: one-hot bounce 0x01->0x02->...->0x80->0x40->...->0x01->0x02. Direction flips at 0x80 and 0x01. Period 14 steps; no repeated end value.
  - BLINK: pattern = ~pattern (0xFF<->0x00).
  - FILL: thermometer 0x00->0x01->0x03->...->0xFF->0x00. Period 9.
- steps=0: never terminates. The step counter wraps modulo 2^STEP_W with no effect.
- stop=1 in RUN: next edge goes to IDLE, pattern=0x00, prescaler=0, no done pulse.
- stop and tick on the same edge: stop wins, no done, no advance.
- cfg_valid during RUN: not accepted (cfg_ready=0), no effect. It is accepted on the first IDLE cycle if still held, including the cycle right after done.
- cfg_mode/cfg_steps changes while RUN have no effect; the latched copies are used.
- rst mid-RUN: immediate return to reset values at that edge; no done.

Test Plan:
1. DIV=4, reset, cfg mode=BINARY steps=3 -> LEDs 0x00 for 4 cycles, 0x01 for 4, 0x02 for 4. Then LEDs 0x00, done high exactly 1 cycle, busy low, cfg_ready high.
2. DIV=4, SCAN steps=0, run 16 ticks -> sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02. busy stays high, no done.
3. DIV=4, FILL steps=10 -> 00,01,03,07,0F,1F,3F,7F,FF,00, then done. BLINK steps=4 -> FF,00,FF,00, then done.
4. DIV=4, BLINK steps=0; assert stop on cycle 6 of RUN -> next cycle LEDs 0, busy 0, done never asserted. stop coincident with a tick -> same result, no advance.
5. Hold cfg_valid with mode=FILL during a BINARY steps=2 run -> not accepted while busy. Accepted the cycle after done; FILL starts at 0x00 one cycle later.
6. rst asserted mid-RUN (SCAN at 0x08) -> next cycle LEDs 0, busy 0, cfg_ready 1, done 0. A new config starts cleanly from 0x01.
